// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Shares one asynchronous 16-bit SRAM between a CPU byte read/write
//            port and a video byte read port, sequencing read/write timing.
// Options  : SRAM_ARBITER_ROUND_ROBIN_EN - round-robin between simultaneous
//            requests (default: fixed video priority).
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int          CPU_AW    = 16,
    parameter int          VID_AW    = 13,
    parameter logic [18:0] CPU_BASE  = 19'h00000,
    parameter logic [18:0] VID_BASE  = 19'h10000,
    parameter int          RD_CYCLES = 2,
    parameter int          WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [VID_AW-1:0] vid_addr,
    output logic [7:0]        vid_rdata,
    output logic              vid_ack,
    output logic [18:0]       sram_a,
    inout  wire  [15:0]       sram_d,
    output logic              sram_wel,
    output logic              sram_lbl,
    output logic              sram_ubl,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WS   = 3'd2,
        S_WP   = 3'd3,
        S_WH   = 3'd4,
        S_ACK  = 3'd5
    } state_t;

    localparam logic [2:0] RD_LOAD = 3'(RD_CYCLES - 1);
    localparam logic [2:0] WR_LOAD = 3'(WR_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [18:0] sram_a_q;
    logic        lbl_q;
    logic        ubl_q;
    logic        wel_q;
    logic        drive_q;
    logic [7:0]  wdata_q;
    logic        vid_sel_q;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  vid_rdata_q;
    logic        cpu_ack_q;
    logic        vid_ack_q;
    logic        busy_q;

    logic [18:0] cpu_word_d;
    logic [18:0] vid_word_d;
    logic        grant_vid_d;
    logic [7:0]  rd_byte_d;

    assign cpu_word_d = CPU_BASE + 19'(cpu_addr[CPU_AW-1:1]);
    assign vid_word_d = VID_BASE + 19'(vid_addr[VID_AW-1:1]);
    // Only one lane is ever enabled, so ubl low means the high byte.
    assign rd_byte_d  = ubl_q ? sram_d[7:0] : sram_d[15:8];

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    logic last_vid_q;
    assign grant_vid_d = vid_req && (!cpu_req || !last_vid_q);
`else
    assign grant_vid_d = vid_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            sram_a_q    <= 19'd0;
            lbl_q       <= 1'b1;
            ubl_q       <= 1'b1;
            wel_q       <= 1'b1;
            drive_q     <= 1'b0;
            wdata_q     <= 8'd0;
            vid_sel_q   <= 1'b0;
            cpu_rdata_q <= 8'd0;
            vid_rdata_q <= 8'd0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
            last_vid_q  <= 1'b1;
`endif
        end else begin
            cpu_ack_q <= 1'b0;
            vid_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (vid_req || cpu_req) begin
                        busy_q    <= 1'b1;
                        vid_sel_q <= grant_vid_d;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
                        last_vid_q <= grant_vid_d;
`endif
                        if (grant_vid_d) begin
                            sram_a_q <= vid_word_d;
                            lbl_q    <= vid_addr[0];
                            ubl_q    <= ~vid_addr[0];
                            cnt_q    <= RD_LOAD;
                            state_q  <= S_RD;
                        end else begin
                            sram_a_q <= cpu_word_d;
                            lbl_q    <= cpu_addr[0];
                            ubl_q    <= ~cpu_addr[0];
                            wdata_q  <= cpu_wdata;
                            if (cpu_we) begin
                                drive_q <= 1'b1;
                                state_q <= S_WS;
                            end else begin
                                cnt_q   <= RD_LOAD;
                                state_q <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == 3'd0) begin
                        if (vid_sel_q) begin
                            vid_rdata_q <= rd_byte_d;
                            vid_ack_q   <= 1'b1;
                        end else begin
                            cpu_rdata_q <= rd_byte_d;
                            cpu_ack_q   <= 1'b1;
                        end
                        lbl_q   <= 1'b1;
                        ubl_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_WS: begin
                    wel_q   <= 1'b0;
                    cnt_q   <= WR_LOAD;
                    state_q <= S_WP;
                end
                S_WP: begin
                    if (cnt_q == 3'd0) begin
                        wel_q   <= 1'b1;
                        state_q <= S_WH;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_WH: begin
                    drive_q   <= 1'b0;
                    lbl_q     <= 1'b1;
                    ubl_q     <= 1'b1;
                    cpu_ack_q <= 1'b1;
                    state_q   <= S_ACK;
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sram_d    = drive_q ? {wdata_q, wdata_q} : 16'hzzzz;
    assign sram_a    = sram_a_q;
    assign sram_wel  = wel_q;
    assign sram_lbl  = lbl_q;
    assign sram_ubl  = ubl_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// Bench for sram_arbiter: directed and random traffic checked every cycle
// against a transaction-timeline model with a behavioural SRAM on the bus.
module tb_sram_arbiter;

    localparam int RD = 2;
    localparam int WR = 2;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    localparam int EXP_FIRST = 2;
`else
    localparam int EXP_FIRST = 1;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cpu_req   = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [15:0] cpu_addr  = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        vid_req   = 1'b0;
    logic [12:0] vid_addr  = 13'h0;
    wire  [7:0]  cpu_rdata, vid_rdata;
    wire         cpu_ack, vid_ack, sram_wel, sram_lbl, sram_ubl, busy;
    wire  [18:0] sram_a;
    wire  [15:0] sram_d;

    logic        c2_req  = 1'b0;
    logic [15:0] c2_addr = 16'h0;
    wire  [7:0]  c2_rdata, v2_rdata;
    wire         c2_ack, v2_ack, w2_wel, w2_lbl, w2_ubl, w2_busy;
    wire  [18:0] w2_a;
    wire  [15:0] w2_d;

    sram_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .sram_a(sram_a), .sram_d(sram_d), .sram_wel(sram_wel),
        .sram_lbl(sram_lbl), .sram_ubl(sram_ubl), .busy(busy)
    );

    sram_arbiter #(.CPU_BASE(19'h7FFFF)) u_wrap (
        .clk(clk), .reset(reset),
        .cpu_req(c2_req), .cpu_we(1'b0), .cpu_addr(c2_addr), .cpu_wdata(8'h00),
        .cpu_rdata(c2_rdata), .cpu_ack(c2_ack),
        .vid_req(1'b0), .vid_addr(13'h0000), .vid_rdata(v2_rdata), .vid_ack(v2_ack),
        .sram_a(w2_a), .sram_d(w2_d), .sram_wel(w2_wel),
        .sram_lbl(w2_lbl), .sram_ubl(w2_ubl), .busy(w2_busy)
    );

    // An undriven bus reads back as all ones.
    pullup pu_d  (sram_d);
    pullup pu_d2 (w2_d);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [logic [18:0]];

    function automatic logic [15:0] mem_rd(input logic [18:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[7:0] ^ 8'hC3, a[15:8] ^ 8'h5A};
    endfunction

    // Model: at most one transaction, described by its grant edge and kind.
    int          cyc = 0, t_g = 0, t_A = 0, free_at = 0;
    bit          t_act = 1'b0, t_wr = 1'b0, t_vid = 1'b0, t_hi = 1'b0, last_vid = 1'b1;
    logic [18:0] t_a = 19'h0;
    logic [7:0]  t_wd = 8'h0, t_rexp = 8'h0, e_cpu_rd = 8'h0, e_vid_rd = 8'h0;

    logic        rd_drive;
    logic [15:0] rd_val;
    always_comb begin
        rd_drive = (!sram_lbl || !sram_ubl) && sram_wel && !(t_act && t_wr);
        rd_val   = mem_rd(sram_a);
    end
    assign sram_d = rd_drive ? rd_val : 16'hzzzz;

    initial begin : sram_write
        logic [15:0] w;
        forever begin
            @(posedge sram_wel);
            if ((!sram_lbl || !sram_ubl) && !$isunknown(sram_d)) begin
                w = mem_rd(sram_a);
                if (!sram_lbl) w[7:0]  = sram_d[7:0];
                if (!sram_ubl) w[15:8] = sram_d[15:8];
                mem[sram_a] = w;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit          pv;
        logic [15:0] word;
        cyc++;
        if (reset) begin
            t_act = 1'b0; free_at = 0; e_cpu_rd = 8'h0; e_vid_rd = 8'h0; last_vid = 1'b1;
            return;
        end
        if (t_act && !t_wr && cyc == t_g + t_A) begin
            if (t_vid) e_vid_rd = t_rexp;
            else       e_cpu_rd = t_rexp;
        end
        if (t_act && cyc > t_g + t_A) t_act = 1'b0;
        if (!t_act && cyc >= free_at && (cpu_req || vid_req)) begin
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
            pv = vid_req && (!cpu_req || !last_vid);
`else
            pv = vid_req;
`endif
            last_vid = pv;
            t_act = 1'b1; t_g = cyc; t_vid = pv; t_wr = !pv && cpu_we;
            t_A = t_wr ? WR + 2 : RD;
            if (pv) begin
                t_a = 19'h10000 + {7'd0, vid_addr[12:1]}; t_hi = vid_addr[0];
            end else begin
                t_a = 19'h00000 + {4'd0, cpu_addr[15:1]}; t_hi = cpu_addr[0];
            end
            t_wd = cpu_wdata;
            word = mem_rd(t_a);
            t_rexp = t_hi ? word[15:8] : word[7:0];
            free_at = cyc + t_A + 2;
        end
    endtask

    task automatic compare();
        int          k;
        logic        e_busy, e_lbl, e_ubl, e_wel, e_ca, e_va;
        logic [15:0] e_d;
        bit          ck_d, ck_a;
        k = cyc - t_g;
        e_busy = 1'b0; e_lbl = 1'b1; e_ubl = 1'b1; e_wel = 1'b1; e_ca = 1'b0; e_va = 1'b0;
        e_d = 16'hFFFF; ck_d = 1'b1; ck_a = 1'b0;
        if (t_act) begin
            e_busy = 1'b1;
            if (k < t_A) begin
                e_lbl = t_hi; e_ubl = !t_hi; ck_a = 1'b1;
                if (t_wr) begin
                    e_d = {t_wd, t_wd};
                    if (k >= 1 && k <= WR) e_wel = 1'b0;
                end else begin
                    ck_d = 1'b0;
                end
            end else if (t_vid) e_va = 1'b1;
            else                e_ca = 1'b1;
        end
        chk("busy", busy, e_busy);
        chk("sram_lbl", sram_lbl, e_lbl);
        chk("sram_ubl", sram_ubl, e_ubl);
        chk("sram_wel", sram_wel, e_wel);
        chk("cpu_ack", cpu_ack, e_ca);
        chk("vid_ack", vid_ack, e_va);
        chk("cpu_rdata", cpu_rdata, e_cpu_rd);
        chk("vid_rdata", vid_rdata, e_vid_rd);
        if (ck_a) chk("sram_a", sram_a, t_a);
        if (ck_d) chk("sram_d", sram_d, e_d);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!reset) compare();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int k_ack, wl, acks, bz;
        mem[19'h10002] = 16'h3C7E;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_wel", sram_wel, 1'b1);
        chk("rst_lbl_ubl", {sram_lbl, sram_ubl}, 2'b11);
        chk("rst_sram_d", sram_d, 16'hFFFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sram_a", sram_a, 19'h0);
        chk("rst_outs", {cpu_ack, vid_ack, cpu_rdata, vid_rdata}, 18'h0);
        @(negedge clk);
        reset = 1'b0;

        // Base 0x7FFFF plus word 1 wraps to word 0.
        tick();
        c2_req = 1'b1; c2_addr = 16'h0002;
        tick();
        c2_req = 1'b0;
        @(negedge clk);
        chk("wrap_sram_a", w2_a, 19'h00000);
        chk("wrap_lbl", w2_lbl, 1'b0);

        // CPU write 0xA5 to byte 3: high lane of word 1.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0003; cpu_wdata = 8'hA5;
        tick();
        cpu_req = 1'b0;
        wl = 0; k_ack = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("wr_sram_a", sram_a, 19'h00001);
                chk("wr_lanes", {sram_ubl, sram_lbl}, 2'b01);
                chk("wr_bus", sram_d, 16'hA5A5);
            end
            if (!sram_wel) wl++;
            if (cpu_ack && k_ack == 0) k_ack = k;
        end
        chk("wr_wel_low_cycles", wl, 2);
        chk("wr_ack_latency", k_ack, 5);

        // Video reads of the preloaded word 0x10002, both lanes.
        for (int i = 0; i < 2; i++) begin
            tick();
            vid_req = 1'b1; vid_addr = 13'(4 + i);
            tick();
            vid_req = 1'b0;
            k_ack = 0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (vid_ack && k_ack == 0) k_ack = k;
            end
            chk("vid_ack_latency", k_ack, 3);
            chk("vid_rdata_lit", vid_rdata, (i == 0) ? 8'h7E : 8'h3C);
        end

        // Simultaneous requests, two rounds; each request held until its ack.
        for (int r = 0; r < 2; r++) begin
            int  first_src, k1, k2;
            bit  gc, gv;
            tick();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'(16 + r);
            vid_req = 1'b1; vid_addr = 13'(6 + r);
            first_src = 0; k1 = 0; k2 = 0; gc = 1'b0; gv = 1'b0;
            for (int n = 1; n <= 20 && !(gc && gv); n++) begin
                @(posedge clk);
                #2;
                if (gc) cpu_req = 1'b0;
                if (gv) vid_req = 1'b0;
                @(negedge clk);
                if (vid_ack && !gv) begin
                    gv = 1'b1;
                    if (first_src == 0) begin first_src = 1; k1 = n; end else k2 = n;
                end
                if (cpu_ack && !gc) begin
                    gc = 1'b1;
                    if (first_src == 0) begin first_src = 2; k1 = n; end else k2 = n;
                end
            end
            cpu_req = 1'b0; vid_req = 1'b0;
            chk("arb_first_src", first_src, EXP_FIRST);
            chk("arb_first_ack_k", k1, 3);
            chk("arb_second_ack_k", k2, 7);
        end

        // CPU read with the request dropped one cycle after grant.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0011;
        tick();
        cpu_req = 1'b0;
        acks = 0; bz = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            if (busy) bz++;
        end
        chk("drop_ack_count", acks, 1);
        chk("drop_busy_cycles", bz, 3);
        chk("drop_busy_after", busy, 1'b0);

        // Random traffic over a small address window so reads hit written data.
        repeat (400) begin
            tick();
            if ($urandom_range(0, 3) == 0) cpu_req = !cpu_req;
            if ($urandom_range(0, 3) == 0) vid_req = !vid_req;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom_range(0, 31));
            cpu_wdata = 8'($urandom);
            vid_addr  = 13'($urandom_range(0, 15));
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (10) tick();

        // Asynchronous reset in the middle of the write pulse.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h5A;
        tick();
        cpu_req = 1'b0;
        tick();
        chk("wp_wel_low", sram_wel, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("arst_wel", sram_wel, 1'b1);
        chk("arst_lanes", {sram_lbl, sram_ubl}, 2'b11);
        chk("arst_busy", busy, 1'b0);
        chk("arst_sram_d", sram_d, 16'hFFFF);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_ack || vid_ack) acks++;
        end
        chk("arst_no_ack", acks, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
